// File: rtl/npu_pkg.sv
// Shared state encoding and default sizing for the NPU write-back scheduler.
package npu_pkg;

    localparam int DEF_N_UNITS  = 16;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 14;
    localparam int DEF_MAX_HOST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/npu_wb_arb.sv
// Host vs write-back arbitration for the shared store RAM port.
// Latency: grants are combinational from host_req/pending; starve_cnt is registered.
// Backpressure: host wins until MAX_HOST consecutive grants, then one write-back word is forced.
module npu_wb_arb #(
    parameter int MAX_HOST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic host_req,
    input  logic pending,
    output logic grant_host,
    output logic grant_wb
);

    localparam int CNT_W = $clog2(MAX_HOST + 1);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        grant_host = host_req && (!pending || (starve_cnt < CNT_W'(MAX_HOST)));
        grant_wb   = pending && !grant_host;
    end

    // Only host grants that delay a pending word count toward starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!pending || grant_wb) begin
            starve_cnt <= '0;
        end else if (grant_host) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/npu_writeback_sched.sv
// Snapshots N_UNITS results on start and streams them to the store RAM, one word per won cycle.
// Latency: first write visible one cycle after the start edge; N_UNITS cycles plus host-won cycles.
// Backpressure: host requests pre-empt the burst, bounded by MAX_HOST consecutive grants.
module npu_writeback_sched
    import npu_pkg::*;
#(
    parameter int N_UNITS  = DEF_N_UNITS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_HOST = DEF_MAX_HOST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_write_back,
    input  logic [N_UNITS*DATA_W-1:0] u_flat,
    input  logic [ADDR_W-1:0]         wb_base_addr,
    input  logic                      host_req,
    input  logic [ADDR_W-1:0]         host_addr,
    output logic                      host_grant,
    output logic [ADDR_W-1:0]         ram_store_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      wr_en,
    output logic                      wb_busy,
    output logic                      stop_write_back,
    output logic                      wb_overrun
);

    localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic [DATA_W-1:0] wb_buf [N_UNITS];
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  idx;
    logic              pending;
    logic              grant_host;
    logic              grant_wb;
    logic              last_word;
    logic              accept_start;

    assign pending      = (state == WRITE);
    assign wb_busy      = pending;
    assign last_word    = grant_wb && (idx == LAST_IDX);
    assign accept_start = (state == IDLE) && start_write_back;

    npu_wb_arb #(
        .MAX_HOST (MAX_HOST)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .host_req   (host_req),
        .pending    (pending),
        .grant_host (grant_host),
        .grant_wb   (grant_wb)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_write_back) state_nxt = WRITE;
            WRITE:   if (last_word)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot storage carries no reset; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (accept_start) begin
            for (int k = 0; k < N_UNITS; k++) begin
                wb_buf[k] <= u_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base            <= '0;
            idx             <= '0;
            host_grant      <= 1'b0;
            wr_en           <= 1'b0;
            ram_store_addr  <= '0;
            ram_wdata       <= '0;
            stop_write_back <= 1'b0;
            wb_overrun      <= 1'b0;
        end else begin
            host_grant      <= grant_host;
            wr_en           <= grant_wb;
            stop_write_back <= last_word;
            if (accept_start) begin
                base <= wb_base_addr;
                idx  <= '0;
            end
            if (pending && start_write_back) begin
                wb_overrun <= 1'b1;
            end
            if (grant_host) begin
                ram_store_addr <= host_addr;
            end else if (grant_wb) begin
                // Address arithmetic wraps silently at the top of the RAM.
                ram_store_addr <= base + ADDR_W'(idx);
                ram_wdata      <= wb_buf[idx];
                idx            <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/npu_writeback_sched.md
Name: npu_writeback_sched

Overview:
Write-back scheduler between the 16-unit NPU compute array and the single-port feature-map store RAM. On a start_write_back pulse it snapshots the 16 unit results u0..u15, then writes them to consecutive RAM addresses, one word per cycle. It shares the RAM port with a host (CPU/debug) requester, giving the host priority with a bounded starvation limit, and pulses stop_write_back when the burst completes.

Parameters:
N_UNITS, 16, number of unit results per burst
DATA_W, 8, result word width
ADDR_W, 14, store RAM address width
MAX_HOST, 4, maximum consecutive host grants while a write-back word is pending

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_write_back  in  1  one-cycle pulse: snapshot results and begin burst
u_flat  in  N_UNITS*DATA_W  unit results; u0 at bits [DATA_W-1:0]
wb_base_addr  in  ADDR_W  first store address, sampled with start_write_back
host_req  in  1  host requests the RAM port for the current cycle
host_addr  in  ADDR_W  host read address
host_grant  out  1  registered; host owns the RAM port this cycle
ram_store_addr  out  ADDR_W  registered RAM address
ram_wdata  out  DATA_W  registered RAM write data
wr_en  out  1  registered RAM write enable
wb_busy  out  1  burst in progress
stop_write_back  out  1  one-cycle pulse coincident with final write
wb_overrun  out  1  sticky flag: start_write_back received while busy

Behaviour:
- Reset (async) clears all outputs, state, idx, starve_cnt and wb_overrun to 0. The buffer contents are don't-care. No stop pulse is generated.
- States: IDLE and WRITE. wb_busy = (state == WRITE).
- IDLE
  - Sample start_write_back at edge E0: latch u_flat into buf[0..N-1], latch base <- wb_base_addr, set idx <- 0, starve_cnt <- 0, and go to WRITE.
  - Every IDLE cycle: host_grant <- host_req, ram_store_addr <- host_addr when granted, wr_en <- 0.
  - If start_write_back and host_req arrive in the same cycle, both are honoured.
- WRITE (decision per edge, outputs visible after that edge)
  - Host wins when host_req && starve_cnt < MAX_HOST: host_grant <- 1, ram_store_addr <- host_addr, wr_en <- 0, starve_cnt++, idx holds.
  - Otherwise write-back wins: wr_en <- 1, host_grant <- 0, ram_store_addr <- (base + idx) mod 2^ADDR_W, ram_wdata <- buf[idx], idx++, starve_cnt <- 0.
  - On the edge that issues idx == N_UNITS-1: stop_write_back <- 1 for one cycle and state <- IDLE. wb_busy therefore drops in the same cycle the final wr_en is visible.
- Latency: with no contention, wr_en is high for exactly N_UNITS cycles, starting one cycle after the start edge. Total burst is N_UNITS cycles plus the number of host-won cycles.
- start_write_back while in WRITE: ignored (buffer not reloaded) and wb_overrun <- 1 (sticky). A start sampled in the cycle stop_write_back is visible is legal: that cycle is already IDLE.
- Address wrap: base + idx wraps modulo 2^ADDR_W with no error.
- ram_wdata holds its last value when wr_en = 0.
- host_grant and wr_en are never high together.

Decomposition:
- Package npu_pkg: state enum (IDLE, WRITE) and default constants for N_UNITS, DATA_W, ADDR_W, MAX_HOST.
- One sub-module, npu_wb_arb: a combinational priority decision plus the starve_cnt register. Inputs: host_req, pending. Outputs: grant_host, grant_wb.
- The top level holds the FSM, the buffer and the address counter.

Test Plan:
- Basic burst: u_k = k+1, base = 0x0100, host_req = 0, pulse start → wr_en high 16 consecutive cycles, addr 0x0100..0x010F, data 1..16. stop_write_back coincides with addr 0x010F; wb_busy high for 16 cycles.
- Host contention: host_req held high from start through the whole burst, MAX_HOST = 4 → repeating pattern of 4 host_grant cycles then 1 write. 16 writes complete in 80 cycles with data still 1..16 in order, and no cycle has host_grant and wr_en both high.
- Wrap: base = 0x3FFE → addresses 0x3FFE, 0x3FFF, 0x0000..0x000D.
- Overrun: second start 5 cycles into a burst with new u values → burst data unchanged and wb_overrun = 1 after that edge. Then a back-to-back start in the stop_write_back cycle → new burst begins the next cycle with no gap.
- Reset mid-burst: assert reset after 7 writes → all outputs 0 immediately, no stop_write_back pulse. After release, host_req is granted and a fresh start writes all 16 words from idx 0.
- IDLE host access: host_req = 1, host_addr = 0x0123, no start → host_grant = 1 and ram_store_addr = 0x0123 one cycle later, wr_en = 0.
